dmem_wbuf: RTL and testbench

- Data-memory responder for the pipelined core's Memory stage. It is the target side of the interface the datapath drives with MemWrite_M, ALUResult_M and WriteData_M, and it returns ReadData_M.
- Word-addressed RAM fronted by a small in-order write buffer, so stores retire in one cycle.
- Loads see the youngest buffered store to the same word (store-to-load forwarding).
- Asserts a stall back to the hazard logic only when the buffer cannot make progress.

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/wbuf_fifo.sv | 75 +++++++
 rtl/dmem_wbuf.sv | 136 +++++++++++++
 tb/tb_dmem_wbuf.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory write-buffer slice.
package dmem_pkg;

    localparam int WORD_BYTES      = 4;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_ADDR_BITS   = 8;
    localparam int DEF_WBUF_DEPTH  = 4;

    // Layout of one buffered store at the default widths: word index above data.
    typedef struct packed {
        logic [DEF_ADDR_BITS-1:0] idx;
        logic [DEF_DATA_W-1:0]    data;
    } wbuf_entry_t;

    // True when a byte address does not fall on a word boundary.
    function automatic logic is_misaligned(input logic [1:0] byte_off);
        return (byte_off != 2'b00);
    endfunction

endpackage

// File: rtl/wbuf_fifo.sv
// In-order circular store buffer; exposes every slot and its valid bit so the
// parent can search it for forwarding.
module wbuf_fifo #(
    parameter int DEPTH   = 4,
    parameter int ENTRY_W = 40,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            push,
    input  logic [ENTRY_W-1:0]              push_entry,
    input  logic                            pop,
    output logic                            full,
    output logic                            empty,
    output logic [CNT_W-1:0]                count,
    output logic [PTR_W-1:0]                head_ptr,
    output logic [DEPTH-1:0]                valid,
    output logic [DEPTH-1:0][ENTRY_W-1:0]   entries
);

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [DEPTH-1:0][ENTRY_W-1:0] mem_r;
    logic [DEPTH-1:0]              valid_r;
    logic [PTR_W-1:0]              head_r;
    logic [PTR_W-1:0]              tail_r;
    logic [CNT_W-1:0]              count_r;
    logic                          full_s;
    logic                          empty_s;
    logic                          push_ok_s;
    logic                          pop_ok_s;

    assign full_s    = (count_r == CNT_FULL);
    assign empty_s   = (count_r == {CNT_W{1'b0}});
    // Refuse to overflow or underflow even if the caller misbehaves.
    assign push_ok_s = push & ~full_s;
    assign pop_ok_s  = pop & ~empty_s;

    // Pointer, occupancy and slot state update.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
            valid_r <= {DEPTH{1'b0}};
            mem_r   <= '0;
        end else begin
            if (pop_ok_s) begin
                valid_r[head_r] <= 1'b0;
                head_r          <= head_r + PTR_ONE;
            end
            if (push_ok_s) begin
                valid_r[tail_r] <= 1'b1;
                mem_r[tail_r]   <= push_entry;
                tail_r          <= tail_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    assign full     = full_s;
    assign empty    = empty_s;
    assign count    = count_r;
    assign head_ptr = head_r;
    assign valid    = valid_r;
    assign entries  = mem_r;

endmodule

// File: rtl/dmem_wbuf.sv
// Memory-stage data RAM with an in-order write buffer, youngest-store load
// forwarding, single-port drain arbitration and a sticky misalignment flag.
module dmem_wbuf
    import dmem_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_BITS  = DEF_ADDR_BITS,
    parameter int WBUF_DEPTH = DEF_WBUF_DEPTH,
    localparam int CNT_W     = $clog2(WBUF_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemWrite_M,
    input  logic              MemRead_M,
    input  logic [31:0]       ALUResult_M,
    input  logic [DATA_W-1:0] WriteData_M,
    output logic [DATA_W-1:0] ReadData_M,
    output logic              Stall_M,
    output logic              MisalignErr,
    output logic [CNT_W-1:0]  wbuf_count
);

    localparam int OFF_BITS  = $clog2(WORD_BYTES);
    localparam int PTR_W     = $clog2(WBUF_DEPTH);
    localparam int ENTRY_W   = ADDR_BITS + DATA_W;
    localparam int RAM_DEPTH = 1 << ADDR_BITS;

    logic [DATA_W-1:0]                  ram_r [RAM_DEPTH];
    logic                               misalign_err_r;

    logic [ADDR_BITS-1:0]               idx_s;
    logic                               req_s;
    logic                               misalign_s;
    logic                               full_s;
    logic                               empty_s;
    logic                               push_s;
    logic                               pop_s;
    logic                               load_s;
    logic [PTR_W-1:0]                   head_ptr_s;
    logic [WBUF_DEPTH-1:0]              valid_s;
    logic [WBUF_DEPTH-1:0][ENTRY_W-1:0] entries_s;
    logic [ENTRY_W-1:0]                 head_entry_s;
    logic [PTR_W-1:0]                   slot_s;
    logic                               fwd_hit_s;
    logic [DATA_W-1:0]                  fwd_data_s;
    logic [DATA_W-1:0]                  read_data_s;
    logic                               unused_addr_s;

    // Upper address bits alias onto the same words.
    assign idx_s         = ALUResult_M[ADDR_BITS+OFF_BITS-1:OFF_BITS];
    assign unused_addr_s = ^ALUResult_M[31:ADDR_BITS+OFF_BITS];

    assign req_s      = MemRead_M | MemWrite_M;
    assign misalign_s = req_s & is_misaligned(ALUResult_M[1:0]);

    // Read+write together is a write; full buffer holds every request.
    assign push_s = MemWrite_M & ~misalign_s & ~full_s;
    assign load_s = MemRead_M & ~MemWrite_M & ~misalign_s & ~full_s;
    // A serviced load owns the RAM port; a full buffer always drains so the
    // held request can go next cycle. Reset discards instead of draining.
    assign pop_s  = ~reset & ~empty_s & (~MemRead_M | full_s);

    wbuf_fifo #(
        .DEPTH   (WBUF_DEPTH),
        .ENTRY_W (ENTRY_W)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push_s),
        .push_entry ({idx_s, WriteData_M}),
        .pop        (pop_s),
        .full       (full_s),
        .empty      (empty_s),
        .count      (wbuf_count),
        .head_ptr   (head_ptr_s),
        .valid      (valid_s),
        .entries    (entries_s)
    );

    assign head_entry_s = entries_s[head_ptr_s];

    // Youngest-match search: walk oldest to youngest so the last hit wins.
    always_comb begin
        fwd_hit_s  = 1'b0;
        fwd_data_s = {DATA_W{1'b0}};
        slot_s     = head_ptr_s;
        for (int k = 0; k < WBUF_DEPTH; k++) begin
            slot_s = head_ptr_s + PTR_W'(k);
            if (valid_s[slot_s] &&
                (entries_s[slot_s][ENTRY_W-1:DATA_W] == idx_s)) begin
                fwd_hit_s  = 1'b1;
                fwd_data_s = entries_s[slot_s][DATA_W-1:0];
            end else begin
                fwd_hit_s  = fwd_hit_s;
                fwd_data_s = fwd_data_s;
            end
        end
    end

    // Load data: buffer hit first, else RAM; zero when no load is serviced.
    always_comb begin
        read_data_s = {DATA_W{1'b0}};
        if (load_s) begin
            if (fwd_hit_s) begin
                read_data_s = fwd_data_s;
            end else begin
                read_data_s = ram_r[idx_s];
            end
        end else begin
            read_data_s = {DATA_W{1'b0}};
        end
    end

    // Drain the head store into the RAM; contents survive reset.
    always_ff @(posedge clk) begin
        if (pop_s) begin
            ram_r[head_entry_s[ENTRY_W-1:DATA_W]] <= head_entry_s[DATA_W-1:0];
        end
    end

    // Sticky misalignment flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_err_r <= 1'b0;
        end else if (misalign_s) begin
            misalign_err_r <= 1'b1;
        end else begin
            misalign_err_r <= misalign_err_r;
        end
    end

    assign ReadData_M  = read_data_s;
    assign Stall_M     = full_s & req_s;
    assign MisalignErr = misalign_err_r;

endmodule

// File: tb/tb_dmem_wbuf.sv
// Directed bench for dmem_wbuf: loads push expected data onto a scoreboard,
// an independent monitor pops and compares whenever a load is serviced.
module tb_dmem_wbuf;

    logic        clk;
    logic        reset;
    logic        MemWrite_M;
    logic        MemRead_M;
    logic [31:0] ALUResult_M;
    logic [31:0] WriteData_M;
    logic [31:0] ReadData_M;
    logic        Stall_M;
    logic        MisalignErr;
    logic [2:0]  wbuf_count;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q [$];
    logic        st;

    dmem_wbuf dut (
        .clk         (clk),
        .reset       (reset),
        .MemWrite_M  (MemWrite_M),
        .MemRead_M   (MemRead_M),
        .ALUResult_M (ALUResult_M),
        .WriteData_M (WriteData_M),
        .ReadData_M  (ReadData_M),
        .Stall_M     (Stall_M),
        .MisalignErr (MisalignErr),
        .wbuf_count  (wbuf_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every serviced load must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && MemRead_M && !MemWrite_M && !Stall_M) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_load: got 0x%08h with no expectation queued", ReadData_M);
            end else begin
                chk("load_data", ReadData_M, exp_q.pop_front());
            end
        end
    end

    // One clock of stimulus starting just after a rising edge; reports Stall_M.
    task automatic cyc(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, output logic stall);
        MemRead_M   = rd;
        MemWrite_M  = wr;
        ALUResult_M = a;
        WriteData_M = d;
        @(negedge clk);
        stall = Stall_M;
        @(posedge clk);
        #1;
        MemRead_M  = 1'b0;
        MemWrite_M = 1'b0;
    endtask

    task automatic idle(input int n);
        logic s;
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'h0, 32'h0, s);
    endtask

    // Store, holding the request while stalled (bounded).
    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic with_rd);
        logic s;
        int   tries;
        tries = 0;
        do begin
            cyc(with_rd, 1'b1, a, d, s);
            tries++;
        end while (s && tries < 8);
        if (s) begin
            n_tests++;
            n_fail++;
            $display("FAIL store_timeout: addr 0x%08h still stalled after %0d cycles", a, tries);
        end
    endtask

    // Load, queueing its expected data once and holding while stalled (bounded).
    task automatic load(input logic [31:0] a, input logic [31:0] exp);
        logic s;
        int   tries;
        exp_q.push_back(exp);
        tries = 0;
        do begin
            cyc(1'b1, 1'b0, a, 32'h0, s);
            tries++;
        end while (s && tries < 8);
        if (s) begin
            n_tests++;
            n_fail++;
            $display("FAIL load_timeout: addr 0x%08h still stalled after %0d cycles", a, tries);
        end
    endtask

    initial begin
        reset       = 1'b1;
        MemWrite_M  = 1'b0;
        MemRead_M   = 1'b0;
        ALUResult_M = 32'h0;
        WriteData_M = 32'h0;
        @(posedge clk);
        #1;
        idle(2);
        reset = 1'b0;

        // Preload RAM word 4, then reset: RAM keeps it, buffer state clears.
        store(32'h10, 32'hDEADBEEF, 1'b0);
        idle(2);
        chk("preload_drained", 32'(wbuf_count), 32'd0);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        chk("reset_count", 32'(wbuf_count), 32'd0);
        chk("reset_stall", 32'(Stall_M), 32'd0);
        chk("reset_misalign", 32'(MisalignErr), 32'd0);
        load(32'h10, 32'hDEADBEEF);
        chk("load_ram_count", 32'(wbuf_count), 32'd0);

        // Two stores to one word; second store's cycle drains the first.
        store(32'h20, 32'h11111111, 1'b0);
        chk("st1_count", 32'(wbuf_count), 32'd1);
        store(32'h20, 32'h22222222, 1'b0);
        chk("st2_count", 32'(wbuf_count), 32'd1);
        load(32'h20, 32'h22222222);
        idle(2);
        chk("st_drained_count", 32'(wbuf_count), 32'd0);
        load(32'h20, 32'h22222222);

        // Fill with read+write stores (no drain), duplicate address inside.
        store(32'h44, 32'hA0A0A0A0, 1'b1);
        store(32'h40, 32'hA1A1A1A1, 1'b1);
        store(32'h40, 32'hA2A2A2A2, 1'b1);
        store(32'h4C, 32'hA3A3A3A3, 1'b1);
        chk("fill_count", 32'(wbuf_count), 32'd4);
        cyc(1'b1, 1'b1, 32'h50, 32'hA4A4A4A4, st);
        chk("full_stall", 32'(st), 32'd1);
        chk("full_drain_count", 32'(wbuf_count), 32'd3);
        cyc(1'b1, 1'b1, 32'h50, 32'hA4A4A4A4, st);
        chk("held_accept_stall", 32'(st), 32'd0);
        chk("held_accept_count", 32'(wbuf_count), 32'd4);
        // Full again: load stalls, head (0x40/A1) drains, then youngest 0x40 wins.
        load(32'h40, 32'hA2A2A2A2);
        chk("load_after_full_count", 32'(wbuf_count), 32'd3);
        load(32'h44, 32'hA0A0A0A0);
        load(32'h50, 32'hA4A4A4A4);
        idle(4);
        chk("fill_drained_count", 32'(wbuf_count), 32'd0);
        load(32'h40, 32'hA2A2A2A2);
        load(32'h4C, 32'hA3A3A3A3);

        // Alternate store/idle: occupancy toggles between 1 and 0.
        for (int i = 0; i < 4; i++) begin
            logic [31:0] a;
            logic [31:0] d;
            a = (i % 2 == 0) ? 32'h60 : 32'h64;
            d = 32'hB0B0B000 + 32'(i);
            store(a, d, 1'b0);
            chk("alt_count_store", 32'(wbuf_count), 32'd1);
            idle(1);
            chk("alt_count_idle", 32'(wbuf_count), 32'd0);
        end
        load(32'h60, 32'hB0B0B002);
        load(32'h64, 32'hB0B0B003);

        // Misaligned load and store: dropped, flag sticky.
        exp_q.push_back(32'h0);
        cyc(1'b1, 1'b0, 32'h22, 32'h0, st);
        chk("misalign_flag", 32'(MisalignErr), 32'd1);
        chk("misalign_count", 32'(wbuf_count), 32'd0);
        cyc(1'b0, 1'b1, 32'h31, 32'h55555555, st);
        chk("misalign_store_count", 32'(wbuf_count), 32'd0);
        idle(2);
        chk("misalign_sticky", 32'(MisalignErr), 32'd1);

        // Reset with buffered stores discards them.
        store(32'h70, 32'hC0C0C0C0, 1'b0);
        store(32'h74, 32'hC1C1C1C1, 1'b0);
        store(32'h78, 32'hC2C2C2C2, 1'b0);
        idle(3);
        store(32'h70, 32'hD0D0D0D0, 1'b1);
        store(32'h74, 32'hD1D1D1D1, 1'b1);
        store(32'h78, 32'hD2D2D2D2, 1'b1);
        chk("prereset_count", 32'(wbuf_count), 32'd3);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        chk("midreset_count", 32'(wbuf_count), 32'd0);
        chk("midreset_stall", 32'(Stall_M), 32'd0);
        chk("midreset_misalign", 32'(MisalignErr), 32'd0);
        load(32'h70, 32'hC0C0C0C0);
        load(32'h74, 32'hC1C1C1C1);
        load(32'h78, 32'hC2C2C2C2);

        idle(1);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog against a hung run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
